// File: rtl/stage4_pkg.sv
// Shared definitions for the pipeline stages: opcode classes, stage-4 FSM states
// and the NOP encoding, plus the opcode-class decoder used by decode/ALU/mem stages.
package stage4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_WB       = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP   = 3'd0,
    CLS_ALU   = 3'd1,
    CLS_LOAD  = 3'd2,
    CLS_STORE = 3'd3,
    CLS_JUMP  = 3'd4
  } op_class_e;

  localparam logic [7:0] NOP_OPCODE = 8'h00;
  localparam logic [3:0] GRP_MISC   = 4'h0;
  localparam logic [3:0] GRP_LOAD   = 4'h1;
  localparam logic [3:0] GRP_STORE  = 4'h2;
  localparam logic [3:0] GRP_JUMP   = 4'h3;

  function automatic op_class_e decode_class(input logic [7:0] opcode);
    op_class_e cls;
    case (opcode[7:4])
      GRP_MISC:  cls = (opcode == NOP_OPCODE) ? CLS_NOP : CLS_ALU;
      GRP_LOAD:  cls = CLS_LOAD;
      GRP_STORE: cls = CLS_STORE;
      GRP_JUMP:  cls = CLS_JUMP;
      default:   cls = CLS_ALU;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/stage4_timeout_ctr.sv
// 4-bit wait counter for memory accesses; tc flags that the next counted cycle
// brings the count up to TIMEOUT.
module stage4_timeout_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [3:0] LAST_VAL = 4'(TIMEOUT - 1);

  logic [3:0] count_r;

  // Count MEM_WAIT cycles without ack; cleared on entry to the wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= 4'd0;
    end else if (clear) begin
      count_r <= 4'd0;
    end else if (enable) begin
      count_r <= count_r + 4'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == LAST_VAL);

endmodule

// File: rtl/stage4_mem_wb.sv
// Pipeline stage 4: executes the memory access (with timeout) and produces the
// register-file writeback and jump strobes.
module stage4_mem_wb
  import stage4_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_in,
  input  logic [7:0] pc_in,
  input  logic [7:0] alu_in,
  input  logic [7:0] opcode_in,
  input  logic [7:0] store_data_in,
  output logic       stall_out,
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack,
  output logic       wb_en,
  output logic [1:0] wb_addr,
  output logic [7:0] wb_data,
  output logic       pc_load,
  output logic [7:0] pc_target,
  output logic       mem_err
);

  state_e     state_r, state_nx;
  op_class_e  cls_s;
  logic       capture_s, mem_op_s, waiting_s, tc_s, timeout_s;

  logic       mem_req_r, mem_req_nx, mem_we_r, mem_we_nx, mem_err_r, mem_err_nx;
  logic [7:0] mem_addr_r, mem_addr_nx, mem_wdata_r, mem_wdata_nx;
  logic [1:0] dst_r, dst_nx, wb_addr_r, wb_addr_nx;
  logic       wb_en_r, wb_en_nx, pc_load_r, pc_load_nx;
  logic [7:0] wb_data_r, wb_data_nx, pc_target_r, pc_target_nx;

  assign cls_s     = decode_class(opcode_in);
  assign capture_s = (state_r == ST_IDLE) && valid_in;
  assign mem_op_s  = (cls_s == CLS_LOAD) || (cls_s == CLS_STORE);
  assign waiting_s = (state_r == ST_MEM_WAIT);
  // An ack on the terminal cycle wins over the timeout.
  assign timeout_s = waiting_s && !mem_ack && tc_s;

  stage4_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout_ctr (
    .clk    (clk),
    .rst    (rst),
    .clear  (capture_s && mem_op_s),
    .enable (waiting_s && !mem_ack),
    .tc     (tc_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_IDLE: begin
        if (capture_s && mem_op_s) state_nx = ST_MEM_WAIT;
        else                       state_nx = ST_IDLE;
      end
      ST_MEM_WAIT: begin
        if (mem_ack)        state_nx = mem_we_r ? ST_IDLE : ST_WB;
        else if (timeout_s) state_nx = ST_IDLE;
        else                state_nx = ST_MEM_WAIT;
      end
      ST_WB:   state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs; data holds, strobes default low.
  always_comb begin
    mem_req_nx   = 1'b0;
    mem_we_nx    = mem_we_r;
    mem_addr_nx  = mem_addr_r;
    mem_wdata_nx = mem_wdata_r;
    dst_nx       = dst_r;
    wb_en_nx     = 1'b0;
    wb_addr_nx   = wb_addr_r;
    wb_data_nx   = wb_data_r;
    pc_load_nx   = 1'b0;
    pc_target_nx = pc_target_r;
    mem_err_nx   = mem_err_r | timeout_s;
    case (state_r)
      ST_IDLE: begin
        if (capture_s) begin
          case (cls_s)
            CLS_ALU: begin
              wb_en_nx   = 1'b1;
              wb_addr_nx = opcode_in[1:0];
              wb_data_nx = alu_in;
            end
            CLS_JUMP: begin
              pc_load_nx   = 1'b1;
              pc_target_nx = alu_in;
            end
            CLS_LOAD, CLS_STORE: begin
              mem_req_nx   = 1'b1;
              mem_we_nx    = (cls_s == CLS_STORE);
              mem_addr_nx  = alu_in;
              mem_wdata_nx = store_data_in;
              dst_nx       = opcode_in[1:0];
            end
            default: begin
              wb_en_nx = 1'b0;
            end
          endcase
        end else begin
          wb_en_nx = 1'b0;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ack) begin
          wb_en_nx   = !mem_we_r;
          wb_addr_nx = mem_we_r ? wb_addr_r : dst_r;
          wb_data_nx = mem_we_r ? wb_data_r : mem_rdata;
        end else begin
          mem_req_nx = !timeout_s;
        end
      end
      default: begin
        mem_req_nx = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 8'h00;
      mem_wdata_r <= 8'h00;
      dst_r       <= 2'd0;
      wb_en_r     <= 1'b0;
      wb_addr_r   <= 2'd0;
      wb_data_r   <= 8'h00;
      pc_load_r   <= 1'b0;
      pc_target_r <= 8'h00;
      mem_err_r   <= 1'b0;
    end else begin
      mem_req_r   <= mem_req_nx;
      mem_we_r    <= mem_we_nx;
      mem_addr_r  <= mem_addr_nx;
      mem_wdata_r <= mem_wdata_nx;
      dst_r       <= dst_nx;
      wb_en_r     <= wb_en_nx;
      wb_addr_r   <= wb_addr_nx;
      wb_data_r   <= wb_data_nx;
      pc_load_r   <= pc_load_nx;
      pc_target_r <= pc_target_nx;
      mem_err_r   <= mem_err_nx;
    end
  end

  assign stall_out = (state_r == ST_MEM_WAIT) || (state_r == ST_WB);
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign wb_en     = wb_en_r;
  assign wb_addr   = wb_addr_r;
  assign wb_data   = wb_data_r;
  assign pc_load   = pc_load_r;
  assign pc_target = pc_target_r;
  assign mem_err   = mem_err_r;

  logic unused_s;
  assign unused_s = ^pc_in;

endmodule

// File: tb/tb_stage4_mem_wb.sv
// Self-checking bench for stage4_mem_wb: directed cases then random instructions
// against a transaction-level model of the stage.
module tb_stage4_mem_wb;

  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_in = 1'b0;
  logic [7:0] pc_in = 8'h00, alu_in = 8'h00, opcode_in = 8'h00, store_data_in = 8'h00;
  logic [7:0] mem_rdata = 8'h00;
  logic       mem_ack = 1'b0;
  logic       stall_out, mem_req, mem_we, wb_en, pc_load, mem_err;
  logic [7:0] mem_addr, mem_wdata, wb_data, pc_target;
  logic [1:0] wb_addr;

  int checks = 0;
  int errors = 0;
  logic exp_err = 1'b0;

  stage4_mem_wb #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .pc_in(pc_in), .alu_in(alu_in),
    .opcode_in(opcode_in), .store_data_in(store_data_in), .stall_out(stall_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .pc_load(pc_load), .pc_target(pc_target), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobes that must be low plus the common invariants.
  task automatic chk_idle_cycle(input string tag);
    chk({tag, ".wb_en"},   {7'd0, wb_en},     8'd0);
    chk({tag, ".pc_load"}, {7'd0, pc_load},   8'd0);
    chk({tag, ".mem_req"}, {7'd0, mem_req},   8'd0);
    chk({tag, ".stall"},   {7'd0, stall_out}, 8'd0);
    chk({tag, ".err"},     {7'd0, mem_err},   {7'd0, exp_err});
  endtask

  // Class derived from the opcode table: 0=NOP 1=ALU 2=LOAD 3=STORE 4=JUMP.
  function automatic int op_kind(input logic [7:0] op);
    if (op == 8'h00)       return 0;
    if (op[7:4] == 4'h1)   return 2;
    if (op[7:4] == 4'h2)   return 3;
    if (op[7:4] == 4'h3)   return 4;
    return 1;
  endfunction

  // Issue one instruction and check every cycle until the stage is idle again.
  // ack_delay: request cycle (1-based) that sees mem_ack; beyond TIMEOUT means none.
  task automatic run_instr(input string tag, input logic [7:0] op, input logic [7:0] alu,
                           input logic [7:0] sd, input int ack_delay, input logic [7:0] rd);
    int kind;
    bit acked;
    kind = op_kind(op);
    opcode_in = op; alu_in = alu; store_data_in = sd; valid_in = 1'b1;
    pc_in = 8'($urandom_range(0, 255));
    tick();
    valid_in = 1'b0;
    opcode_in = 8'($urandom_range(0, 255));
    alu_in = 8'($urandom_range(0, 255));
    if (kind == 1) begin
      chk({tag, ".alu_wb_en"},   {7'd0, wb_en},     8'd1);
      chk({tag, ".alu_wb_addr"}, {6'd0, wb_addr},   {6'd0, op[1:0]});
      chk({tag, ".alu_wb_data"}, wb_data,           alu);
      chk({tag, ".alu_stall"},   {7'd0, stall_out}, 8'd0);
      chk({tag, ".alu_pcl"},     {7'd0, pc_load},   8'd0);
      chk({tag, ".alu_req"},     {7'd0, mem_req},   8'd0);
    end else if (kind == 4) begin
      chk({tag, ".jmp_pc_load"}, {7'd0, pc_load},   8'd1);
      chk({tag, ".jmp_target"},  pc_target,         alu);
      chk({tag, ".jmp_wb_en"},   {7'd0, wb_en},     8'd0);
      chk({tag, ".jmp_req"},     {7'd0, mem_req},   8'd0);
      tick();
      chk({tag, ".jmp_pulse_end"}, {7'd0, pc_load}, 8'd0);
    end else if (kind == 0) begin
      chk_idle_cycle({tag, ".nop"});
    end else begin
      acked = 1'b0;
      for (int k = 1; k <= TIMEOUT && !acked; k++) begin
        chk({tag, ".req"},   {7'd0, mem_req},   8'd1);
        chk({tag, ".we"},    {7'd0, mem_we},    {7'd0, kind == 3});
        chk({tag, ".addr"},  mem_addr,          alu);
        if (kind == 3) chk({tag, ".wdata"}, mem_wdata, sd);
        chk({tag, ".stall"}, {7'd0, stall_out}, 8'd1);
        chk({tag, ".wb_en"}, {7'd0, wb_en},     8'd0);
        chk({tag, ".pcl"},   {7'd0, pc_load},   8'd0);
        if (k == ack_delay) begin
          mem_ack = 1'b1; mem_rdata = rd; acked = 1'b1;
        end
        tick();
        mem_ack = 1'b0;
        mem_rdata = 8'($urandom_range(0, 255));
      end
      chk({tag, ".req_drop"}, {7'd0, mem_req}, 8'd0);
      if (!acked) exp_err = 1'b1;
      if (acked && kind == 2) begin
        chk({tag, ".ld_wb_en"},   {7'd0, wb_en},     8'd1);
        chk({tag, ".ld_wb_addr"}, {6'd0, wb_addr},   {6'd0, op[1:0]});
        chk({tag, ".ld_wb_data"}, wb_data,           rd);
        chk({tag, ".ld_stall"},   {7'd0, stall_out}, 8'd1);
        chk({tag, ".ld_err"},     {7'd0, mem_err},   {7'd0, exp_err});
        tick();
      end
      chk_idle_cycle({tag, ".end"});
    end
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst.stall", {7'd0, stall_out}, 8'd0);
    chk("rst.req",   {7'd0, mem_req},   8'd0);
    chk("rst.wb_en", {7'd0, wb_en},     8'd0);
    chk("rst.pcl",   {7'd0, pc_load},   8'd0);
    chk("rst.err",   {7'd0, mem_err},   8'd0);
    chk("rst.addr",  mem_addr,          8'h00);
    chk("rst.wdata", wb_data,           8'h00);
    rst = 1'b0;
    tick();

    run_instr("alu42",   8'h42, 8'h5A, 8'h00, 0, 8'h00);
    run_instr("ld13",    8'h13, 8'h20, 8'h00, 3, 8'hC3);
    run_instr("st20",    8'h20, 8'h7F, 8'h99, 1, 8'h00);
    run_instr("ld_edge", 8'h11, 8'h33, 8'h00, TIMEOUT, 8'hA5);
    chk("edge.no_err", {7'd0, mem_err}, 8'd0);
    run_instr("nop",     8'h00, 8'h12, 8'h00, 0, 8'h00);
    run_instr("alu0x",   8'h05, 8'h66, 8'h00, 0, 8'h00);
    run_instr("ld_to",   8'h12, 8'h40, 8'h00, TIMEOUT + 1, 8'h00);
    chk("to.err", {7'd0, mem_err}, 8'd1);
    run_instr("alu_after_to", 8'hF1, 8'h0D, 8'h00, 0, 8'h00);
    run_instr("jmp30",   8'h30, 8'h44, 8'h00, 0, 8'h00);

    // Back-to-back ALU ops and ignored valid_in / ack outside MEM_WAIT
    opcode_in = 8'h41; alu_in = 8'h11; valid_in = 1'b1;
    tick();
    opcode_in = 8'h86; alu_in = 8'h22; mem_ack = 1'b1;
    chk("b2b.first_en",   {7'd0, wb_en},   8'd1);
    chk("b2b.first_data", wb_data,         8'h11);
    tick();
    valid_in = 1'b0; mem_ack = 1'b0;
    chk("b2b.second_en",   {7'd0, wb_en},   8'd1);
    chk("b2b.second_addr", {6'd0, wb_addr}, 8'd2);
    chk("b2b.second_data", wb_data,         8'h22);
    tick();
    chk_idle_cycle("b2b.after");

    // Reset during MEM_WAIT discards the access and clears the sticky error
    opcode_in = 8'h10; alu_in = 8'h55; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    tick();
    chk("rstw.req_before", {7'd0, mem_req}, 8'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_err = 1'b0;
    chk("rstw.req", {7'd0, mem_req},   8'd0);
    chk("rstw.err", {7'd0, mem_err},   8'd0);
    chk("rstw.stall", {7'd0, stall_out}, 8'd0);
    mem_ack = 1'b1; mem_rdata = 8'hEE;
    tick();
    mem_ack = 1'b0;
    chk("rstw.late_ack", {7'd0, wb_en}, 8'd0);
    tick();
    chk("rstw.late_ack2", {7'd0, wb_en}, 8'd0);

    // Random instructions
    for (int n = 0; n < 40; n++) begin
      logic [7:0] op;
      op = 8'($urandom_range(0, 255));
      if (n % 3 == 0) op = {4'($urandom_range(1, 3)), 4'($urandom_range(0, 15))};
      run_instr($sformatf("rnd%0d", n), op, 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), int'($urandom_range(1, TIMEOUT + 2)),
                8'($urandom_range(0, 255)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage4_mem_wb.md
STAGE4_MEM_WB -- requirements
Module: stage4_mem_wb

Interface
REQ-001 Parameter: TIMEOUT, default 15, maximum MEM_WAIT cycles before the access is abandoned (legal range 1..15).
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 valid_in  in  1  stage-3 buffer holds an instruction for this stage.
REQ-005 pc_in  in  8  PC of the instruction, from the stage-3 buffer.
REQ-006 alu_in  in  8  ALU result (data, memory address or jump target).
REQ-007 opcode_in  in  8  opcode from the stage-3 buffer.
REQ-008 store_data_in  in  8  data to write on STORE.
REQ-009 stall_out  out  1  upstream holds its buffer contents while high.
REQ-010 mem_req  out  1  data-memory request, held until ack.
REQ-011 mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
REQ-012 mem_addr  out  8  memory address.
REQ-013 mem_wdata  out  8  memory write data.
REQ-014 mem_rdata  in  8  read data; valid when mem_ack is high.
REQ-015 mem_ack  in  1  single-cycle completion strobe.
REQ-016 wb_en  out  1  one-cycle register-file write strobe.
REQ-017 wb_addr  out  2  destination register, equal to opcode[1:0].
REQ-018 wb_data  out  8  writeback data.
REQ-019 pc_load  out  1  one-cycle jump strobe.
REQ-020 pc_target  out  8  jump target.
REQ-021 mem_err  out  1  sticky timeout flag.

Function
REQ-022 Opcode classes are decoded from opcode[7:4]:
- 0x0 = NOP when the full opcode is 0x00; any other opcode with opcode[7:4]=0x0 is an ALU op.
- 0x1 = LOAD; 0x2 = STORE; 0x3 = JUMP.
- All other values are ALU ops.
REQ-023 The FSM has three states: IDLE, MEM_WAIT and WB.
REQ-024 stall_out is high exactly when the state is MEM_WAIT or WB.
REQ-025 Capture: an instruction is captured in IDLE when valid_in=1. valid_in is ignored in any other state.
REQ-026 ALU op: wb_en=1, wb_data=alu_in and wb_addr=opcode_in[1:0] in the cycle after capture; the state stays IDLE.
REQ-027 NOP, or valid_in=0: no strobe in the following cycle.
REQ-028 JUMP: pc_load=1 and pc_target=alu_in in the cycle after capture; no writeback.
REQ-029 LOAD/STORE on capture:
- Move to MEM_WAIT.
- Next cycle: mem_req=1, mem_addr=alu_in, mem_we=1 for STORE, mem_wdata=store_data_in.
- The address, write data and destination are registered at capture and held stable until the access ends.
REQ-030 MEM_WAIT with mem_ack=1:
- mem_req drops the next cycle.
- LOAD: register mem_rdata and go to WB.
- STORE: go to IDLE.
REQ-031 WB: wb_en=1, wb_data=the captured read data, wb_addr=the captured opcode[1:0] for exactly one cycle; then go to IDLE.
REQ-032 Timeout:
- A 4-bit counter is cleared on entry to MEM_WAIT and increments each MEM_WAIT cycle without ack.
- When it reaches TIMEOUT: mem_req drops, mem_err is set, no writeback occurs, and the state returns to IDLE.
REQ-033 mem_ack in the same cycle the counter reaches TIMEOUT is treated as success; mem_err is not set.
REQ-034 mem_ack seen outside MEM_WAIT is ignored.
REQ-035 mem_err stays set until reset.
REQ-036 wb_en, pc_load and mem_req are never high together.
REQ-037 Throughput: ALU ops and JUMPs sustain one instruction per cycle. A LOAD occupies at least 3 cycles; a STORE occupies at least 2 cycles.

Reset
REQ-038 On rst=1 at a clock edge:
- State goes to IDLE and the counter to 0.
- All outputs go to 0, including mem_err and all registered data.
REQ-039 Reset in MEM_WAIT or WB: mem_req and wb_en are 0 from the next cycle; the pending writeback is discarded.

Structure
REQ-040 The opcode class encodings, the FSM state encodings and the NOP value (8'h00) shall live in a shared package, reused by the decode and ALU stages.
REQ-041 The timeout counter shall be a single sub-module, stage4_timeout_ctr (clear, enable and a terminal-count output).

Verification
REQ-042 ALU op 0x42 with alu_in=0x5A -> next cycle wb_en=1, wb_addr=2, wb_data=0x5A, stall_out=0.
REQ-043 LOAD 0x13 with alu_in=0x20; ack after 3 cycles with rdata=0xC3:
- mem_req is high for 3 cycles with mem_addr=0x20 and mem_we=0.
- wb_en=1, wb_addr=3, wb_data=0xC3 one cycle after the ack.
- stall_out is high throughout.
REQ-044 STORE 0x20 with alu_in=0x7F and store_data_in=0x99; ack on the first request cycle -> mem_we=1, mem_wdata=0x99, no wb_en, back to IDLE.
REQ-045 LOAD with no ack -> mem_req is high for 15 cycles, then drops; mem_err=1; no wb_en; the next ALU op completes normally.
REQ-046 JUMP 0x30 with alu_in=0x44 -> pc_load=1, pc_target=0x44 for one cycle. Back-to-back ALU ops produce wb_en on consecutive cycles.
REQ-047 rst asserted during MEM_WAIT -> mem_req=0 and mem_err=0 next cycle; an ack arriving afterwards produces no writeback.
